lab3_x_feeder: RTL

- Upstream stage for the 5-input function block: it produces the 5-bit operand x and a valid strobe for that block.
- Serial mode: assembles x from a framed, MSB-first serial bit stream.
- Sweep mode: steps x through all 32 codes 0..31 in order, for exhaustive exercise of the function block.
- Output handshake is valid/ready; x is held stable until it is accepted.

---
 rtl/lab3_x_feeder_if.sv | 28 ++
 rtl/lab3_x_feeder.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/lab3_x_feeder_if.sv
// Operand/handshake bundle between the x feeder and the 5-input function block.
// master = feeder side, slave = consumer/stimulus side.
interface lab3_x_feeder_if #(
    parameter int WIDTH = 5
);
    logic             mode;
    logic             sin_valid;
    logic             sin_start;
    logic             sin_data;
    logic             x_ready;
    logic [WIDTH-1:0] x;
    logic             x_valid;
    logic             busy;
    logic [7:0]       frame_cnt;
    logic             ovr;
    logic             done;
    logic             perr;

    modport master (
        input  mode, sin_valid, sin_start, sin_data, x_ready,
        output x, x_valid, busy, frame_cnt, ovr, done, perr
    );

    modport slave (
        output mode, sin_valid, sin_start, sin_data, x_ready,
        input  x, x_valid, busy, frame_cnt, ovr, done, perr
    );
endinterface

// File: rtl/lab3_x_feeder.sv
// Operand feeder: serial MSB-first frame assembly or exhaustive 0..SWEEP_LAST sweep.
// Optional macro LAB3_FEEDER_PARITY_EN adds a trailing even-parity bit to serial frames.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | nothing pending; mode and frame starts are sampled here
// S_SHIFT | collecting serial frame bits
// S_HOLD  | serial word presented on x, waiting for handshake
// S_SWEEP | presenting sweep counter on x, advancing per handshake
module lab3_x_feeder #(
    parameter int WIDTH      = 5,
    parameter int SWEEP_LAST = 31
) (
    input  logic               clk,
    input  logic               rst_n,
    lab3_x_feeder_if.master    bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_HOLD  = 2'd2,
        S_SWEEP = 2'd3
    } state_t;

`ifdef LAB3_FEEDER_PARITY_EN
    localparam int FRAME_BITS = WIDTH + 1;
`else
    localparam int FRAME_BITS = WIDTH;
`endif
    localparam int CNT_W = 3;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_BITS - 1);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [FRAME_BITS-2:0] r_shreg;
    logic [CNT_W-1:0]      r_bitcnt;
    logic [WIDTH-1:0]      r_x;
    logic [7:0]            r_frame_cnt;
    logic                  r_ovr;
    logic                  r_done;
    logic                  r_perr;

    logic [FRAME_BITS-1:0] w_next_shreg;
    logic [WIDTH-1:0]      w_word;
    logic                  w_par_ok;
    logic                  w_start;
    logic                  w_hs;
    logic                  w_frame_end;
    logic                  w_sweep_end;

    logic                  w_x_valid;
    logic                  w_busy;
    logic                  w_load_first;
    logic                  w_shift_in;
    logic                  w_commit;
    logic                  w_ovr_evt;
    logic                  w_perr_evt;
    logic                  w_sweep_init;
    logic                  w_sweep_inc;
    logic                  w_done_evt;

    assign w_next_shreg = {r_shreg, bus.sin_data};
    assign w_start      = bus.sin_valid & bus.sin_start;
    assign w_hs         = bus.x_ready & ((r_state == S_HOLD) | (r_state == S_SWEEP));
    assign w_frame_end  = (r_state == S_SHIFT) & bus.sin_valid & ~bus.sin_start
                          & (r_bitcnt == LAST_IDX);
    assign w_sweep_end  = (r_x == WIDTH'(SWEEP_LAST));

`ifdef LAB3_FEEDER_PARITY_EN
    // Data sits above the parity bit; even parity means the whole frame XORs to 0.
    assign w_word   = w_next_shreg[FRAME_BITS-1 -: WIDTH];
    assign w_par_ok = ~(^w_next_shreg);
`else
    assign w_word   = w_next_shreg;
    assign w_par_ok = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.mode) begin
                    w_state_nxt = S_SWEEP;
                end else if (w_start) begin
                    w_state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (w_frame_end) begin
                    w_state_nxt = w_par_ok ? S_HOLD : S_IDLE;
                end
            end
            S_HOLD: begin
                if (w_hs) begin
                    w_state_nxt = w_start ? S_SHIFT : S_IDLE;
                end
            end
            S_SWEEP: begin
                if (w_hs && w_sweep_end) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_x_valid    = (r_state == S_HOLD) || (r_state == S_SWEEP);
        w_busy       = (r_state != S_IDLE);
        w_load_first = 1'b0;
        w_shift_in   = 1'b0;
        w_commit     = 1'b0;
        w_ovr_evt    = 1'b0;
        w_perr_evt   = 1'b0;
        w_sweep_init = 1'b0;
        w_sweep_inc  = 1'b0;
        w_done_evt   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.mode) begin
                    w_sweep_init = 1'b1;
                end else if (w_start) begin
                    w_load_first = 1'b1;
                end
            end
            S_SHIFT: begin
                if (w_start) begin
                    w_load_first = 1'b1;
                end else if (w_frame_end) begin
                    w_commit   = w_par_ok;
                    w_perr_evt = ~w_par_ok;
                end else if (bus.sin_valid) begin
                    w_shift_in = 1'b1;
                end
            end
            S_HOLD: begin
                if (w_hs && w_start) begin
                    w_load_first = 1'b1;
                end else if (bus.sin_valid) begin
                    w_ovr_evt = 1'b1;
                end
            end
            S_SWEEP: begin
                if (w_hs) begin
                    w_done_evt  = w_sweep_end;
                    w_sweep_inc = ~w_sweep_end;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shreg     <= '0;
            r_bitcnt    <= '0;
            r_x         <= '0;
            r_frame_cnt <= '0;
            r_ovr       <= 1'b0;
            r_done      <= 1'b0;
            r_perr      <= 1'b0;
        end else begin
            r_ovr  <= w_ovr_evt;
            r_done <= w_done_evt;
            r_perr <= w_perr_evt;
            if (w_hs) begin
                r_frame_cnt <= r_frame_cnt + 8'd1;
            end
            if (w_load_first) begin
                r_shreg  <= (FRAME_BITS-1)'(bus.sin_data);
                r_bitcnt <= CNT_W'(1);
            end else if (w_shift_in) begin
                r_shreg  <= w_next_shreg[FRAME_BITS-2:0];
                r_bitcnt <= r_bitcnt + CNT_W'(1);
            end else if (w_commit || w_perr_evt) begin
                r_shreg  <= '0;
                r_bitcnt <= '0;
            end
            if (w_commit) begin
                r_x <= w_word;
            end else if (w_sweep_init) begin
                r_x <= '0;
            end else if (w_sweep_inc) begin
                r_x <= r_x + WIDTH'(1);
            end
        end
    end

    assign bus.x         = r_x;
    assign bus.x_valid   = w_x_valid;
    assign bus.busy      = w_busy;
    assign bus.frame_cnt = r_frame_cnt;
    assign bus.ovr       = r_ovr;
    assign bus.done      = r_done;
    assign bus.perr      = r_perr;

endmodule
